clock_ratio_detector: RTL
=========================

# clock_ratio_detector

Measures the period and phase lengths of a clock-like signal generated in the `clk` domain, such as the output of the team's clock divider, counted in `clk` cycles. It is the receiving end of the divider: it reports the recovered ratio, shows when that ratio has been stable long enough to count as locked, and flags a stopped input. It sits beside divider instances as a self-check and bring-up monitor.

## Interface
- `W`, 16: width of the phase and period counters.
- `LOCK_COUNT`, 4: number of consecutive identical periods needed before `locked` asserts. Must be ≥ 1.
- `clk` input, 1: system clock. All logic is on the rising edge.
- `rst` input, 1: reset. Synchronous and active-high.
- `clk_in` input, 1: signal under measurement. It must be synchronous to `clk`. It is sampled on every `clk` rising edge with no synchronizer.
- `high_cnt` output, W: number of samples in the last complete period where `clk_in` was 1.
- `low_cnt` output, W: number of samples in the last complete period where `clk_in` was 0.
- `period` output, W+1: `high_cnt + low_cnt`, computed at full width with no truncation.
- `valid` output, 1: one-cycle pulse; all three count outputs updated this cycle.
- `locked` output, 1: the last `LOCK_COUNT` periods were identical.
- `timeout` output, 1: sticky; no edge arrived within 2^W−1 cycles.

## Operation
- Internal signals:
  - `prev` holds the previous sample of `clk_in`.
  - A rising edge is `clk_in & ~prev`; a falling edge is `~clk_in & prev`.
- FSM states:
  - IDLE: wait for a rising edge. When one is seen, go to HIGH with `hc = 1` and `lc = 0`.
  - HIGH: add 1 to `hc` on each sample of 1. A falling edge goes to LOW with `lc = 1`.
  - LOW: add 1 to `lc` on each sample of 0. A rising edge closes the period:
    - register `high_cnt = hc`, `low_cnt = lc` and `period`, and pulse `valid`;
    - restart with `hc = 1` and `lc = 0`, then go to HIGH.
- The first partial period after reset or timeout is never reported.
- Lock tracking:
  - On each `valid`, compare the new (`hc`, `lc`) with the previously reported pair.
  - If they match, `match_cnt` increments and saturates at `LOCK_COUNT`. The first period after IDLE counts as 1.
  - If they differ, `match_cnt` returns to 1.
  - `locked = (match_cnt == LOCK_COUNT)`.
  - `locked` changes only in the cycle `valid` is high, or on timeout or reset.
- Timeout:
  - Applies when the active counter (`hc` in HIGH, `lc` in LOW) reaches 2^W−1 and the input is still in the same phase.
  - Actions: set `timeout`, clear `locked` and `match_cnt`, go to IDLE. The count outputs hold their last values.
  - `timeout` stays high until `rst` or the next `valid`.
- Reset gives: all outputs 0, `prev = 0`, state IDLE.

## Timing
- `valid`, the counts and `locked` are registered at the same `clk` edge that first samples the closing `clk_in` = 1. This is one `clk` cycle after `clk_in` rises.
- `period` is exactly the number of samples between two consecutive rising-edge samples. Example: `clk_in` toggling on every `clk` cycle gives `period` = 2.
- Minimum measurable period is 2: one high sample and one low sample.
- A `rst` asserted in any state takes effect at that edge. It overrides a simultaneous `valid` or timeout. No `valid` is produced in the cycle `rst` is sampled high.
- If a rising edge and counter saturation happen in the same cycle, the edge wins: the period is reported and no timeout occurs.

## Configuration
- `CLOCK_RATIO_DUTY_CHECK_EN`:
  - When defined, the block adds an output `duty_err` (1 bit, reset to 0).
  - `duty_err` is registered with each `valid` as `1` when `|high_cnt − low_cnt| > 1`, and `0` otherwise.
  - With `duty_err` = 1, `locked` still follows the period-match rules but is held at 0.
  - When not defined, the port does not exist and `locked` is unaffected by duty cycle.

## Test plan
- `clk_in` toggling every cycle after release of `rst` → `valid` pulses every 2 cycles with `high_cnt` = 1, `low_cnt` = 1, `period` = 2; `locked` = 1 on the 4th `valid`.
- 3 high, 3 low repeating, then switch to 5 high, 5 low → `period` goes 6 → 10. `locked` drops with the first `valid` reporting 10 and reasserts on the 4th consecutive 10.
- W = 8, `clk_in` held high after one rising edge → `timeout` = 1 when the 255th high sample is seen, `locked` = 0, counts unchanged. The next full period gives `valid` and clears `timeout`.
- `rst` pulsed for 1 cycle in the middle of a LOW phase at ratio 8 → all outputs 0. The first `valid` arrives only after one full post-reset period following the first rising edge.
- With `CLOCK_RATIO_DUTY_CHECK_EN` defined, a 2-high/4-low pattern → `period` = 6, `duty_err` = 1, `locked` stays 0. A 3/3 pattern → `duty_err` = 0 and `locked` = 1 after 4 periods.

Source files
------------

// File: rtl/clock_ratio_detector.sv
`default_nettype none
// ============================================================================
// Module   : clock_ratio_detector
// Purpose  : Measures the high phase, low phase and full period of a
//            clock-like signal that is generated in the clk domain. It reports
//            the recovered ratio, signals lock once the ratio repeats, and
//            flags an input that has stopped toggling.
// Ports    : clk      - system clock; all logic is on the rising edge
//            rst      - synchronous active-high reset
//            clk_in   - signal under measurement, synchronous to clk
//            high_cnt - samples at 1 in the last complete period   [W-1:0]
//            low_cnt  - samples at 0 in the last complete period   [W-1:0]
//            period   - high_cnt + low_cnt at full width            [W:0]
//            valid    - one-cycle pulse when the three counts update
//            locked   - the last LOCK_COUNT periods were identical
//            timeout  - sticky; no edge within 2^W-1 cycles
//            duty_err - only with CLOCK_RATIO_DUTY_CHECK_EN defined:
//                       |high_cnt - low_cnt| > 1 for the last period
// Options  : CLOCK_RATIO_DUTY_CHECK_EN adds duty_err and holds locked low
//            while the duty cycle is unbalanced.
// Revision : 1.0 - initial release
// ============================================================================
module clock_ratio_detector #(
  parameter int W          = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_in,
  output logic [W-1:0] high_cnt,
  output logic [W-1:0] low_cnt,
  output logic [W:0]   period,
  output logic         valid,
  output logic         locked,
  output logic         timeout
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
  ,
  output logic         duty_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_C = MW'(LOCK_COUNT);
  // A phase counter sitting here that sees one more sample of the same level
  // would reach 2^W-1, which is the stopped-input condition.
  localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

  logic [1:0]    state_q,    state_d;
  logic          prev_q,     prev_d;
  logic [W-1:0]  hc_q,       hc_d;
  logic [W-1:0]  lc_q,       lc_d;
  logic [W-1:0]  high_cnt_q, high_cnt_d;
  logic [W-1:0]  low_cnt_q,  low_cnt_d;
  logic [W:0]    period_q,   period_d;
  logic          valid_q,    valid_d;
  logic          locked_q,   locked_d;
  logic          timeout_q,  timeout_d;
  logic [MW-1:0] match_q,    match_d;
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
  logic          duty_q,     duty_d;
  logic [W-1:0]  diff;
`endif

  logic rise, fall, same_pair;

  assign rise      = clk_in & ~prev_q;
  assign fall      = ~clk_in & prev_q;
  assign same_pair = (hc_q == high_cnt_q) && (lc_q == low_cnt_q);

  always_comb begin
    state_d    = state_q;
    prev_d     = clk_in;
    hc_d       = hc_q;
    lc_d       = lc_q;
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    timeout_d  = timeout_q;
    match_d    = match_q;
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
    duty_d     = duty_q;
    diff       = (hc_q > lc_q) ? (hc_q - lc_q) : (lc_q - hc_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_HIGH;
          hc_d    = {{(W-1){1'b0}}, 1'b1};
          lc_d    = '0;
        end
      end

      S_HIGH: begin
        if (fall) begin
          state_d = S_LOW;
          lc_d    = {{(W-1){1'b0}}, 1'b1};
        end else if (hc_q == CNT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end

      S_LOW: begin
        // The rising edge is checked first so that a period closing on the
        // same sample that would saturate the counter is still reported.
        if (rise) begin
          state_d    = S_HIGH;
          high_cnt_d = hc_q;
          low_cnt_d  = lc_q;
          period_d   = {1'b0, hc_q} + {1'b0, lc_q};
          valid_d    = 1'b1;
          timeout_d  = 1'b0;
          hc_d       = {{(W-1){1'b0}}, 1'b1};
          lc_d       = '0;
          // match_q is 0 after IDLE, so the first reported period counts
          // as 1 whether or not it equals the stale pair on the outputs.
          if (!same_pair) begin
            match_d = {{(MW-1){1'b0}}, 1'b1};
          end else if (match_q != LOCK_C) begin
            match_d = match_q + 1'b1;
          end
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
          duty_d   = (diff > {{(W-1){1'b0}}, 1'b1});
          locked_d = (match_d == LOCK_C) && !duty_d;
`else
          locked_d = (match_d == LOCK_C);
`endif
        end else if (lc_q == CNT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
        end else begin
          lc_d = lc_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prev_q     <= 1'b0;
      hc_q       <= '0;
      lc_q       <= '0;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      match_q    <= '0;
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
      duty_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      hc_q       <= hc_d;
      lc_q       <= lc_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
      match_q    <= match_d;
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
      duty_q     <= duty_d;
`endif
    end
  end

  assign high_cnt = high_cnt_q;
  assign low_cnt  = low_cnt_q;
  assign period   = period_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
  assign timeout  = timeout_q;
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
  assign duty_err = duty_q;
`endif

endmodule
`default_nettype wire
